// File: rtl/bt656_line_slicer.sv
// BT.656 receive slicer: parses EAV/SAV timing codes, tracks field/line and
// recovers bytes painted into active-video luma (MSB first, one bit per N luma).
module bt656_line_slicer #(
  parameter int unsigned SAMPLES_PER_BIT = 5,
  parameter int unsigned THRESHOLD       = 128,
  parameter int unsigned FIRST_DATA_LINE = 20,
  parameter int unsigned LAST_DATA_LINE  = 259,
  parameter int unsigned LOCK_COUNT      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] td_data,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       line_start,
  output logic       frame_start,
  output logic       field,
  output logic [9:0] line_num,
  output logic       locked,
  output logic       sync_err
);

  localparam logic [1:0] S_SEARCH = 2'd0;
  localparam logic [1:0] S_P1     = 2'd1;
  localparam logic [1:0] S_P2     = 2'd2;
  localparam logic [1:0] S_P3     = 2'd3;

  localparam int unsigned LCW        = $clog2(LOCK_COUNT + 1);
  localparam logic [LCW-1:0] LOCK_MAX = LCW'(LOCK_COUNT);
  localparam logic [11:0] SUM_LEVEL  = 12'(THRESHOLD * SAMPLES_PER_BIT);
  localparam logic [7:0]  LUMA_LAST  = 8'(SAMPLES_PER_BIT - 1);
  localparam logic [9:0]  LINE_FIRST = 10'(FIRST_DATA_LINE);
  localparam logic [9:0]  LINE_LAST  = 10'(LAST_DATA_LINE);
  localparam logic [10:0] SAMP_LAST  = 11'd1439;

  logic [7:0]     d_r;
  logic [1:0]     state;
  logic [LCW-1:0] lock_cnt;
  logic           active;
  logic [10:0]    samp_cnt;
  logic [10:0]    acc;
  logic [7:0]     lum_cnt;
  logic [2:0]     bit_cnt;
  logic [7:0]     shreg;

  logic           xy_f, xy_v, xy_h, xy_ok, in_range, bit_val;
  logic [LCW-1:0] lock_inc;
  logic [10:0]    sum_next;
  logic [7:0]     byte_next;

  always_comb begin
    xy_f      = d_r[6];
    xy_v      = d_r[5];
    xy_h      = d_r[4];
    xy_ok     = d_r[7] && (d_r[3] == (xy_v ^ xy_h)) && (d_r[2] == (xy_f ^ xy_h)) &&
                (d_r[1] == (xy_f ^ xy_v)) && (d_r[0] == (xy_f ^ xy_v ^ xy_h));
    lock_inc  = (lock_cnt == LOCK_MAX) ? lock_cnt : lock_cnt + 1'b1;
    in_range  = (line_num >= LINE_FIRST) && (line_num <= LINE_LAST);
    sum_next  = acc + {3'b000, d_r};
    bit_val   = ({1'b0, sum_next} >= SUM_LEVEL);
    byte_next = {shreg[6:0], bit_val};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_r         <= '0;
      state       <= S_SEARCH;
      lock_cnt    <= '0;
      active      <= 1'b0;
      samp_cnt    <= '0;
      acc         <= '0;
      lum_cnt     <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      field       <= 1'b0;
      line_num    <= '0;
      locked      <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      d_r         <= td_data;
      data_valid  <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      sync_err    <= 1'b0;

      case (state)
        S_SEARCH: state <= (d_r == 8'hFF) ? S_P1 : S_SEARCH;
        S_P1:     state <= (d_r == 8'h00) ? S_P2 : (d_r == 8'hFF) ? S_P1 : S_SEARCH;
        S_P2:     state <= (d_r == 8'h00) ? S_P3 : (d_r == 8'hFF) ? S_P1 : S_SEARCH;
        default:  state <= S_SEARCH;
      endcase

      // A timing code always wins over sample processing on the same cycle.
      if (state == S_P3) begin
        if (!xy_ok) begin
          sync_err <= 1'b1;
          lock_cnt <= '0;
          locked   <= 1'b0;
          active   <= 1'b0;
        end else begin
          lock_cnt <= lock_inc;
          locked   <= (lock_inc >= LOCK_MAX);
          if (xy_h) begin
            active <= 1'b0;
            if (xy_f != field) begin
              field       <= xy_f;
              line_num    <= '0;
              frame_start <= ~xy_f;
            end else if (line_num != 10'h3FF) begin
              line_num <= line_num + 1'b1;
            end
          end else if (locked && !xy_v && in_range) begin
            active     <= 1'b1;
            line_start <= 1'b1;
            samp_cnt   <= '0;
            acc        <= '0;
            lum_cnt    <= '0;
            bit_cnt    <= '0;
          end
        end
      end else if (active) begin
        samp_cnt <= samp_cnt + 1'b1;
        if (samp_cnt == SAMP_LAST) active <= 1'b0;
        if (samp_cnt[0]) begin
          if (lum_cnt == LUMA_LAST) begin
            acc     <= '0;
            lum_cnt <= '0;
            shreg   <= byte_next;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) begin
              data_out   <= byte_next;
              data_valid <= 1'b1;
            end
          end else begin
            acc     <= sum_next;
            lum_cnt <= lum_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bt656_line_slicer.sv
// Directed bench for bt656_line_slicer: drives BT.656 code/sample sequences and
// checks lock, line tracking, gating and recovered bytes against hand values.
module tb_bt656_line_slicer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] td_data = '0;
  logic [7:0] data_out;
  logic       data_valid, line_start, frame_start, field, locked, sync_err;
  logic [9:0] line_num;

  bt656_line_slicer #(
    .SAMPLES_PER_BIT(5),
    .THRESHOLD(128),
    .FIRST_DATA_LINE(20),
    .LAST_DATA_LINE(259),
    .LOCK_COUNT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .td_data(td_data),
    .data_out(data_out), .data_valid(data_valid), .line_start(line_start),
    .frame_start(frame_start), .field(field), .line_num(line_num),
    .locked(locked), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0, cyc = 0;
  int n_ls = 0, n_fs = 0, n_se = 0;
  logic [7:0] vq[$];
  int         tq[$];
  int         c0, bad;

  logic [7:0] pat [18] = '{8'hA5, 8'h3C, 8'h00, 8'hFF, 8'h81, 8'h7E, 8'h12, 8'h34, 8'h56,
                           8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h0F, 8'hC3, 8'h5A, 8'hE7};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xy(input logic f, input logic v, input logic h);
    return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
  endfunction

  // One clock: drive a byte, take the edge, then log any output events.
  task automatic step(input logic [7:0] b);
    td_data = b;
    @(posedge clk);
    #1;
    cyc++;
    if (data_valid) begin
      vq.push_back(data_out);
      tq.push_back(cyc);
    end
    if (line_start)  n_ls++;
    if (frame_start) n_fs++;
    if (sync_err)    n_se++;
  endtask

  task automatic trs(input logic f, input logic v, input logic h);
    step(8'hFF); step(8'h00); step(8'h00); step(xy(f, v, h));
  endtask

  task automatic eav(input logic f, input logic v);
    trs(f, v, 1'b1);
    step(8'h10);
  endtask

  task automatic luma(input logic [7:0] y);
    step(8'h80);
    step(y);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--)
      for (int j = 0; j < 5; j++) luma(b[i] ? 8'd235 : 8'd16);
  endtask

  task automatic luma5(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                       input logic [7:0] d, input logic [7:0] e);
    luma(a); luma(b); luma(c); luma(d); luma(e);
  endtask

  task automatic clear_log();
    vq.delete();
    tq.delete();
    n_ls = 0;
  endtask

  initial begin
    // Reset with noise on the bus.
    for (int i = 0; i < 6; i++) step(8'($urandom));
    chk("rst_data_out", 32'(data_out), 0);
    chk("rst_data_valid", 32'(data_valid), 0);
    chk("rst_line_start", 32'(line_start), 0);
    chk("rst_frame_start", 32'(frame_start), 0);
    chk("rst_field", 32'(field), 0);
    chk("rst_line_num", 32'(line_num), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_sync_err", 32'(sync_err), 0);
    rst_n = 1'b1;
    step(8'h10); step(8'h10);
    n_fs = 0; n_se = 0; n_ls = 0;

    // Lock acquisition: three field-1 codes, then a field-0 code.
    eav(1'b1, 1'b1); eav(1'b1, 1'b1); eav(1'b1, 1'b1);
    chk("lock_after3", 32'(locked), 0);
    chk("field_after3", 32'(field), 1);
    chk("line_after3", 32'(line_num), 2);
    chk("no_fs_0to1", 32'(n_fs), 0);
    trs(1'b0, 1'b1, 1'b1);
    chk("lock_at_xy4", 32'(locked), 0);
    step(8'h10);
    chk("lock_after4", 32'(locked), 1);
    chk("frame_start_pulse", 32'(frame_start), 1);
    chk("line_reset_on_f", 32'(line_num), 0);
    step(8'h10);
    chk("frame_start_1cyc", 32'(frame_start), 0);

    // Line 19 is below the data band.
    for (int i = 0; i < 19; i++) eav(1'b0, 1'b0);
    chk("line19", 32'(line_num), 19);
    clear_log();
    trs(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 50; i++) luma(8'd235);
    chk("l19_no_ls", 32'(n_ls), 0);
    chk("l19_no_dv", 32'(vq.size()), 0);
    eav(1'b0, 1'b0);

    // Full data line on line 20.
    chk("line20", 32'(line_num), 20);
    clear_log();
    trs(1'b0, 1'b0, 1'b0);
    c0 = cyc;
    step(8'h80);
    chk("l20_ls_pulse", 32'(line_start), 1);
    step(8'd235);
    chk("l20_ls_1cyc", 32'(line_start), 0);
    for (int j = 0; j < 4; j++) luma(8'd235);
    for (int i = 6; i >= 0; i--)
      for (int j = 0; j < 5; j++) luma(pat[0][i] ? 8'd235 : 8'd16);
    for (int k = 1; k < 18; k++) send_byte(pat[k]);
    step(8'h80); step(8'h80);
    chk("l20_strobes", 32'(vq.size()), 18);
    chk("l20_first_latency", (tq.size() > 0) ? 32'(tq[0]) : 32'hFFFF_FFFF, 32'(c0 + 81));
    chk("l20_first_byte", (vq.size() > 0) ? 32'(vq[0]) : 32'hFFFF_FFFF, 32'hA5);
    bad = 0;
    for (int k = 0; k < 18; k++) begin
      if (k >= vq.size()) bad++;
      else if (vq[k] !== pat[k]) bad++;
    end
    chk("l20_all_bytes", 32'(bad), 0);
    bad = 0;
    for (int k = 1; k < tq.size(); k++) if (tq[k] - tq[k-1] != 80) bad++;
    chk("l20_spacing", 32'(bad), 0);
    eav(1'b0, 1'b0);

    // Threshold boundary (640 -> 1, 639 -> 0) and early EAV after 100 luma.
    chk("line21", 32'(line_num), 21);
    clear_log();
    trs(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      luma5(8'd128, 8'd128, 8'd128, 8'd128, 8'd128);
      luma5(8'd128, 8'd128, 8'd128, 8'd128, 8'd127);
    end
    for (int i = 0; i < 4; i++) luma5(8'd235, 8'd235, 8'd16, 8'd16, 8'd137);
    for (int i = 0; i < 4; i++) luma5(8'd235, 8'd235, 8'd16, 8'd16, 8'd138);
    for (int i = 0; i < 20; i++) luma(8'd235);
    eav(1'b0, 1'b0);
    step(8'h80); step(8'h80);
    chk("early_eav_strobes", 32'(vq.size()), 2);
    chk("thr_byte0", (vq.size() > 0) ? 32'(vq[0]) : 32'hFFFF_FFFF, 32'hAA);
    chk("thr_byte1", (vq.size() > 1) ? 32'(vq[1]) : 32'hFFFF_FFFF, 32'h0F);
    chk("early_eav_line", 32'(line_num), 22);

    // Vertical blanking SAV on an in-range line.
    clear_log();
    trs(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 50; i++) luma(8'd235);
    chk("vblank_no_ls", 32'(n_ls), 0);
    chk("vblank_no_dv", 32'(vq.size()), 0);

    // Last data line 259 is inclusive; 260 is out.
    for (int i = 0; i < 237; i++) eav(1'b0, 1'b0);
    chk("line259", 32'(line_num), 259);
    clear_log();
    trs(1'b0, 1'b0, 1'b0);
    send_byte(8'h5A);
    step(8'h80); step(8'h80);
    chk("l259_ls", 32'(n_ls), 1);
    chk("l259_byte", (vq.size() == 1) ? 32'(vq[0]) : 32'hFFFF_FFFF, 32'h5A);
    eav(1'b0, 1'b0);
    clear_log();
    trs(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 50; i++) luma(8'd235);
    chk("l260_no_ls", 32'(n_ls), 0);
    chk("l260_no_dv", 32'(vq.size()), 0);

    // Field 0 -> 1 resets line without a frame_start.
    n_fs = 0;
    eav(1'b1, 1'b0);
    chk("f01_line", 32'(line_num), 0);
    chk("f01_field", 32'(field), 1);
    chk("f01_no_fs", 32'(n_fs), 0);
    for (int i = 0; i < 20; i++) eav(1'b1, 1'b0);
    chk("sync_err_none", 32'(n_se), 0);

    // Bad parity XY mid-window.
    clear_log();
    trs(1'b1, 1'b0, 1'b0);
    send_byte(8'hC3);
    step(8'h80); step(8'hFF); step(8'h00); step(8'h00); step(8'h81);
    step(8'h80);
    chk("bad_xy_sync_err", 32'(sync_err), 1);
    chk("bad_xy_unlock", 32'(locked), 0);
    step(8'h80);
    chk("sync_err_1cyc", 32'(sync_err), 0);
    send_byte(8'hFF);
    send_byte(8'hFF);
    chk("bad_xy_strobes", 32'(vq.size()), 1);
    chk("bad_xy_byte", (vq.size() > 0) ? 32'(vq[0]) : 32'hFFFF_FFFF, 32'hC3);
    chk("sync_err_count", 32'(n_se), 1);

    // Asynchronous reset mid-stream, then re-lock.
    rst_n = 1'b0;
    #2;
    chk("arst_data_out", 32'(data_out), 0);
    chk("arst_field", 32'(field), 0);
    chk("arst_line_num", 32'(line_num), 0);
    step(8'h10);
    rst_n = 1'b1;
    eav(1'b0, 1'b1); eav(1'b0, 1'b1); eav(1'b0, 1'b1);
    chk("relock_after3", 32'(locked), 0);
    eav(1'b0, 1'b1);
    chk("relock_after4", 32'(locked), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
